// File: rtl/prog_loader.sv
// Nibble-stream program loader: packs host nibbles into 8-bit words for instruction memory.
// Define CHECKSUM_EN to require a trailing 8-bit checksum before the CPU is released.
module prog_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          host_valid,
  input  logic [3:0]    host_nib,
  output logic          host_ready,
  output logic          load,
  output logic [7:0]    instr_o,
  output logic          state,
  output logic          busy,
  output logic [AW-1:0] count,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE, RX_HI, RX_LO, WRITE, CK_HI, CK_LO, RUN, ERR
  } st_t;

  st_t           st_q, st_d;
  logic [AW-1:0] count_q, count_d;
  logic [7:0]    instr_q, instr_d;
  logic          hs;

`ifdef CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [3:0] ck_q, ck_d;
`endif

  assign hs = host_valid & host_ready;

  always_comb begin
    st_d    = st_q;
    count_d = count_q;
    instr_d = instr_q;
`ifdef CHECKSUM_EN
    sum_d   = sum_q;
    ck_d    = ck_q;
`endif
    unique case (st_q)
      RX_HI: if (hs) begin
        instr_d[7:4] = host_nib;
        st_d         = RX_LO;
      end
      RX_LO: if (hs) begin
        instr_d[3:0] = host_nib;
        st_d         = WRITE;
      end
      WRITE: begin
        count_d = count_q + AW'(1);
`ifdef CHECKSUM_EN
        sum_d = sum_q + instr_q;
        st_d  = (count_q == AW'(DEPTH - 1)) ? CK_HI : RX_HI;
`else
        st_d  = (count_q == AW'(DEPTH - 1)) ? RUN : RX_HI;
`endif
      end
`ifdef CHECKSUM_EN
      CK_HI: if (hs) begin
        ck_d = host_nib;
        st_d = CK_LO;
      end
      CK_LO: if (hs) begin
        st_d = ({ck_q, host_nib} == sum_q) ? RUN : ERR;
      end
`endif
      default: ;
    endcase
    // Restart wins over any handshake in the same cycle.
    if (start) begin
      st_d    = RX_HI;
      count_d = '0;
`ifdef CHECKSUM_EN
      sum_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= IDLE;
      count_q <= '0;
      instr_q <= '0;
`ifdef CHECKSUM_EN
      sum_q   <= '0;
      ck_q    <= '0;
`endif
    end else begin
      st_q    <= st_d;
      count_q <= count_d;
      instr_q <= instr_d;
`ifdef CHECKSUM_EN
      sum_q   <= sum_d;
      ck_q    <= ck_d;
`endif
    end
  end

  always_comb begin
    host_ready = (st_q == RX_HI) || (st_q == RX_LO) ||
                 (st_q == CK_HI) || (st_q == CK_LO);
    busy       = host_ready || (st_q == WRITE);
    load       = (st_q == WRITE);
    state      = (st_q == RUN);
  end

  assign instr_o = instr_q;
  assign count   = count_q;

`ifdef CHECKSUM_EN
  assign err = (st_q == ERR);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: reset, streaming load, stalls, restarts,
// and (with CHECKSUM_EN) checksum pass/fail.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       host_valid = 1'b0;
  logic [3:0] host_nib = 4'h0;
  logic       host_ready, load, state, busy, err;
  logic [7:0] instr_o;
  logic [3:0] count;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int load_n = 0;
  logic [7:0] load_val [0:255];
  int         load_cyc [0:255];

  prog_loader #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .host_valid(host_valid), .host_nib(host_nib),
    .host_ready(host_ready), .load(load), .instr_o(instr_o),
    .state(state), .busy(busy), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (load && load_n < 256) begin
      load_val[load_n] = instr_o;
      load_cyc[load_n] = cycle;
      load_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one nibble and hold it until accepted (bounded wait).
  task automatic send_nib(input logic [3:0] nib, input bit gaps);
    int n;
    if (gaps) begin
      host_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    host_valid = 1'b1;
    host_nib   = nib;
    n = 0;
    while (!host_ready && n < 20) begin
      tick();
      n++;
    end
    if (!host_ready) begin
      failures++;
      $display("FAIL send_nib: host_ready=%0b required 1 within 20 cycles", host_ready);
    end
    tick();
    if (gaps) host_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit gaps);
    send_nib(w[7:4], gaps);
    send_nib(w[3:0], gaps);
  endtask

  // Ends a session after the last word: checksum nibbles when enabled.
  task automatic finish_session(input logic [7:0] ck);
`ifdef CHECKSUM_EN
    send_nib(ck[7:4], 1'b0);
    send_nib(ck[3:0], 1'b0);
`else
    if (ck == 8'hxx) ;
    tick();
`endif
    host_valid = 1'b0;
  endtask

  task automatic test_reset();
    pulse_start();
    send_nib(4'hA, 1'b0);
    host_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({host_ready, load, state, busy, err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 00000",
               {host_ready, load, state, busy, err});
    end
    checks++;
    if (count !== 4'd0 || instr_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: count=%0d instr=%h required 0/00", count, instr_o);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (host_ready !== 1'b0 || busy !== 1'b0 || state !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: ready=%b busy=%b state=%b required 0/0/0",
               host_ready, busy, state);
    end
  endtask

  task automatic check_loads(input string name, input int base,
                             input logic [7:0] first, input bit spacing);
    checks++;
    if (load_n - base !== 16) begin
      failures++;
      $display("FAIL %s_count: loads=%0d required 16", name, load_n - base);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (load_val[base + i] !== first + 8'(i)) begin
        failures++;
        $display("FAIL %s_data[%0d]: got %h required %h",
                 name, i, load_val[base + i], first + 8'(i));
      end
      if (spacing && i > 0) begin
        checks++;
        if (load_cyc[base + i] - load_cyc[base + i - 1] !== 3) begin
          failures++;
          $display("FAIL %s_spacing[%0d]: got %0d required 3", name, i,
                   load_cyc[base + i] - load_cyc[base + i - 1]);
        end
      end
    end
  endtask

  task automatic check_run(input string name);
    checks++;
    if (state !== 1'b1 || busy !== 1'b0 || count !== 4'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL %s_run: state=%b busy=%b count=%0d err=%b required 1/0/0/0",
               name, state, busy, count, err);
    end
  endtask

  task automatic test_stream();
    int base;
    base = load_n;
    pulse_start();
    checks++;
    if (host_ready !== 1'b1 || busy !== 1'b1 || count !== 4'd0) begin
      failures++;
      $display("FAIL start_rx: ready=%b busy=%b count=%0d required 1/1/0",
               host_ready, busy, count);
    end
    for (int i = 0; i < 16; i++) begin
      send_word(8'h10 + 8'(i), 1'b0);
      if (i == 0) begin
        checks++;
        if (load !== 1'b1 || instr_o !== 8'h10) begin
          failures++;
          $display("FAIL first_load: load=%b instr=%h required 1/10", load, instr_o);
        end
      end
    end
    finish_session(8'h78);
    check_loads("stream", base, 8'h10, 1'b1);
    check_run("stream");
  endtask

  task automatic test_stall();
    int base;
    base = load_n;
    pulse_start();
    for (int i = 0; i < 16; i++) send_word(8'h10 + 8'(i), 1'b1);
    finish_session(8'h78);
    check_loads("stall", base, 8'h10, 1'b0);
    check_run("stall");
  endtask

  task automatic test_restart();
    int base;
    pulse_start();
    for (int i = 0; i < 5; i++) send_word(8'h40 + 8'(i), 1'b0);
    send_nib(4'hF, 1'b0);
    checks++;
    if (count !== 4'd5 || host_ready !== 1'b1) begin
      failures++;
      $display("FAIL pre_restart: count=%0d ready=%b required 5/1", count, host_ready);
    end
    base = load_n;
    host_valid = 1'b1;
    host_nib   = 4'h5;
    pulse_start();
    host_valid = 1'b0;
    checks++;
    if (count !== 4'd0 || load !== 1'b0 || busy !== 1'b1 || load_n !== base) begin
      failures++;
      $display("FAIL restart: count=%0d load=%b busy=%b loads=%0d required 0/0/1/%0d",
               count, load, busy, load_n, base);
    end
    tick();
    checks++;
    if (load !== 1'b0 || host_ready !== 1'b1) begin
      failures++;
      $display("FAIL restart_rxhi: load=%b ready=%b required 0/1", load, host_ready);
    end
    base = load_n;
    for (int i = 0; i < 16; i++) send_word(8'h20 + 8'(i), 1'b0);
    finish_session(8'h78);
    check_loads("reload", base, 8'h20, 1'b1);
    check_run("reload");
  endtask

  task automatic test_run_restart();
    pulse_start();
    checks++;
    if (state !== 1'b0 || busy !== 1'b1 || count !== 4'd0) begin
      failures++;
      $display("FAIL run_restart: state=%b busy=%b count=%0d required 0/1/0",
               state, busy, count);
    end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    for (int i = 0; i < 16; i++) send_word(8'h01, 1'b0);
    finish_session(8'h10);
    check_run("ck_ok");
    pulse_start();
    for (int i = 0; i < 16; i++) send_word(8'h01, 1'b0);
    finish_session(8'h11);
    checks++;
    if (err !== 1'b1 || state !== 1'b0 || host_ready !== 1'b0) begin
      failures++;
      $display("FAIL ck_err: err=%b state=%b ready=%b required 1/0/0",
               err, state, host_ready);
    end
    repeat (3) tick();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL ck_err_hold: err=%b required 1", err);
    end
    pulse_start();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1 || count !== 4'd0) begin
      failures++;
      $display("FAIL ck_clear: err=%b busy=%b count=%0d required 0/1/0",
               err, busy, count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    test_reset();
    test_stream();
    test_stall();
    test_restart();
    test_run_restart();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
